// File: rtl/mac_pkg.sv
// Shared types and default sizes for the MAC accumulator.
package mac_pkg;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_LEN_W = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_DONE
   } state_t;

endpackage

// File: rtl/mac_accumulator.sv
// Block accumulator for unsigned products with sticky carry-out and
// dropped-product flags, valid/ready result handshake.
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [WIDTH-1:0] prod,
   input  logic             prod_valid,
   output logic [WIDTH-1:0] sum,
   output logic             sum_valid,
   input  logic             sum_ready,
   output logic             overflow,
   output logic             dropped,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             ovf_q, ovf_d;
   logic             drop_q, drop_d;
   logic [LEN_W:0]   cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;

   logic [WIDTH:0]   add_w;
   logic [LEN_W:0]   cnt_inc;
   logic             restart;

   assign add_w   = {1'b0, sum_q} + {1'b0, prod};
   assign cnt_inc = cnt_q + 1'b1;
   assign restart = start &
                    ((state_q == S_IDLE) |
                     ((state_q == S_DONE) & sum_ready));

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      drop_d  = drop_q;
      cnt_d   = cnt_q;
      len_d   = len_q;

      unique case (state_q)
         S_ACCUM: begin
            if (prod_valid) begin
               sum_d = add_w[WIDTH-1:0];
               ovf_d = ovf_q | add_w[WIDTH];
               cnt_d = cnt_inc;
               if (cnt_inc == {1'b0, len_q}) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (sum_ready && !start) begin
               state_d = S_IDLE;
            end
         end
         default: ;
      endcase

      // Restart also covers DONE->ACCUM without passing through IDLE
      if (restart) begin
         sum_d  = '0;
         ovf_d  = 1'b0;
         drop_d = 1'b0;
         cnt_d  = '0;
         if (len != '0) begin
            len_d   = len;
            state_d = S_ACCUM;
         end else begin
            state_d = S_DONE;
         end
      end

      if (prod_valid && (state_q != S_ACCUM)) begin
         drop_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= 1'b0;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   assign sum       = sum_q;
   assign sum_valid = (state_q == S_DONE);
   assign overflow  = ovf_q;
   assign dropped   = drop_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter: WIDTH, default 64, product and sum width in bits.
REQ-002 Parameter: LEN_W, default 8, width of the block-length field.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a new accumulation block; sampled only in IDLE or with the DONE handshake.
REQ-006 len  input  LEN_W  number of products in the block; sampled with start.
REQ-007 prod  input  WIDTH  unsigned product from the upstream multiplier.
REQ-008 prod_valid  input  1  prod is valid this cycle; upstream has no backpressure.
REQ-009 sum  output  WIDTH  accumulated result, registered.
REQ-010 sum_valid  output  1  sum and overflow are final.
REQ-011 sum_ready  input  1  consumer accepts sum; handshake = sum_valid & sum_ready.
REQ-012 overflow  output  1  sticky carry-out of the accumulation in the current block.
REQ-013 dropped  output  1  sticky: a product arrived while not in ACCUM.
REQ-014 busy  output  1  high in ACCUM and DONE.

Function
REQ-015 The block shall implement three states: IDLE, ACCUM, DONE.
REQ-016 IDLE with start=1 and len!=0: clear sum, overflow, dropped and the count; latch len; go to ACCUM.
REQ-017 IDLE with start=1 and len=0: clear sum, overflow, dropped; go to DONE, so sum_valid=1 with sum=0 on the next cycle.
REQ-018 ACCUM with prod_valid=1: sum <= (sum + prod) mod 2^WIDTH; overflow <= overflow | carry-out; count increments.
REQ-019 ACCUM shall leave sum and count unchanged on a cycle with prod_valid=0.
REQ-020 When the accepted product is the len-th, go to DONE; sum_valid shall be high on the following cycle (latency 1 after the last product).
REQ-021 DONE shall hold sum, overflow and sum_valid stable until the handshake.
REQ-022 DONE handshake with start=0 goes to IDLE on the next cycle; sum_valid is then low.
REQ-023 DONE handshake with start=1 applies REQ-016/017 directly, skipping IDLE (back-to-back blocks).
REQ-024 start in ACCUM, or in DONE without the handshake, shall be ignored.
REQ-025 prod_valid outside ACCUM shall not alter sum or overflow and shall set dropped; dropped clears only on an accepted start or reset.
REQ-026 A product accepted in the same cycle as a DONE-to-ACCUM restart shall be dropped, with dropped set (ACCUM begins the next cycle).
REQ-027 The count shall be LEN_W+1 bits wide; len=2^LEN_W-1 shall complete without wrap.

Reset
REQ-028 reset=1 at a rising edge shall force IDLE with sum=0, sum_valid=0, overflow=0, dropped=0, busy=0 and count=0, taking priority over all inputs.
REQ-029 Reset during ACCUM or DONE shall abort the block without emitting a result.

Structure
REQ-030 A shared package mac_pkg shall hold the state enum typedef and default WIDTH/LEN_W constants.
REQ-031 The design shall be a single module with no sub-modules; the adder with carry-out is inline.

Verification
REQ-032 len=3, prods 5,7,11 on consecutive cycles -> sum_valid high the cycle after 11, sum=23, overflow=0, dropped=0.
REQ-033 len=2, prods 0xFFFF_FFFF_FFFF_FFFF then 2 -> sum=1, overflow=1.
REQ-034 start with len=0 -> next cycle sum_valid=1, sum=0; sum_ready=1 -> IDLE, busy=0.
REQ-035 sum_ready low for 5 cycles in DONE with prod_valid pulsed (prod=99) -> sum unchanged, dropped=1, sum_valid held high.
REQ-036 Handshake with start=1, len=1 in the same cycle, then prod=9 -> no IDLE cycle, next result sum=9.
REQ-037 len=4, reset asserted after the first product -> next cycle IDLE with all outputs 0; no sum_valid ever asserted.
